apb4_axil_bridge: RTL
=====================

Name: apb4_axil_bridge

Overview:
APB4 completer to AXI4-Lite manager bridge. It is the reverse of the SoC's AXI-Lite-to-APB path: an APB requester, such as a debug or DMA APB port, reaches AXI-Lite memory-mapped targets through it. It handles one transfer at a time. Each APB transfer becomes exactly one AXI-Lite read or write, and pready is held off until the AXI response returns.

Parameters:
ADDR_WIDTH, 32, width of paddr/awaddr/araddr
ALIGN_CHECK, 1, 1 = reject paddr[1:0]!=0 with pslverr and issue no AXI transaction; 0 = pass the address through unchanged

Ports:
clk_i  in  1  single clock
rst_i  in  1  reset, asynchronous, active-high
s_apb_paddr  in  ADDR_WIDTH  APB address
s_apb_pprot  in  3  APB protection, forwarded to awprot/arprot
s_apb_psel  in  1  select
s_apb_penable  in  1  access phase
s_apb_pwrite  in  1  1 = write
s_apb_pwdata  in  32  write data
s_apb_pstrb  in  4  byte strobes
s_apb_pready  out  1  transfer complete
s_apb_prdata  out  32  read data, valid only while pready=1
s_apb_pslverr  out  1  error, valid only while pready=1
m_axi_awvalid/awready  out/in  1  AW handshake
m_axi_awaddr  out  ADDR_WIDTH; m_axi_awprot  out  3
m_axi_wvalid/wready  out/in  1  W handshake
m_axi_wdata  out  32; m_axi_wstrb  out  4
m_axi_bvalid/bready  in/out  1; m_axi_bresp  in  2
m_axi_arvalid/arready  out/in  1; m_axi_araddr  out  ADDR_WIDTH; m_axi_arprot  out  3
m_axi_rvalid/rready  in/out  1; m_axi_rdata  in  32; m_axi_rresp  in  2

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: every output is 0, including all valid/ready signals, pready, pslverr, prdata, addresses, wdata, wstrb and prot. FSM goes to IDLE.
- All outputs are registered.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE:
  - Trigger is the APB setup phase (psel=1, penable=0) in cycle T0.
  - Latch paddr, pwrite, pwdata, pstrb and pprot.
  - If ALIGN_CHECK and paddr[1:0]!=0: go to DONE with err=1, rdata=0.
  - Else if write: go to WR_REQ with awvalid=wvalid=1 from T1.
  - Else (read): go to RD_REQ with arvalid=1 from T1.
- WR_REQ:
  - AW and W are tracked independently with per-channel done flags.
  - awvalid drops the cycle after aw handshake; wvalid drops the cycle after w handshake.
  - Once both handshakes have completed, go to WR_RESP with bready=1.
  - Valids are never withdrawn before their handshake. Address, data, strobe and prot stay stable while valid.
- WR_RESP: on bvalid&bready, capture err=bresp[1] (SLVERR or DECERR), force captured rdata=0, drop bready, go to DONE.
- RD_REQ: hold arvalid until arready; then go to RD_RESP with rready=1.
- RD_RESP: on rvalid&rready, capture rdata and err=rresp[1], drop rready, go to DONE.
- DONE:
  - pready=1 for exactly one cycle, with prdata=captured rdata and pslverr=err.
  - Then IDLE; pready, prdata and pslverr return to 0.
- Best-case latency: T0 setup; T1 valid plus same-cycle ready; T2 bvalid/rvalid; T3 pready. The access phase then lasts 3 cycles.
- Misaligned transfer: pready at T1 (zero wait states).
- EXOKAY (2'b01) is treated as success.
- pstrb=0 on a write is forwarded as wstrb=0. It is not special-cased.
- Setup phases seen while not in IDLE are ignored; APB protocol guarantees none occur.
- psel dropped mid-transfer (requester violation): the AXI transaction still completes. DONE is still entered and pready pulses once. There is no abort path.
- Reset asserted mid-transaction: outputs clear immediately (asynchronously) and AXI valids drop. The downstream AXI target is reset in the same domain.
- No timeout. A hung AXI target stalls APB indefinitely, by design.

Decomposition:
- Shared package:
  - FSM state enum (6 states, 3 bits).
  - AXI resp constants: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Default-prot constant 3'b000.
- No sub-module: a single FSM with two channel-done flags fits in about 200 lines.

Test Plan:
- Zero-wait write: paddr=0x0300_6004, pwdata=0xDEAD_BEEF, pstrb=0xF; target gives awready=wready=1 at T1 and bvalid with OKAY at T2 -> awaddr=0x0300_6004, wdata=0xDEAD_BEEF, wstrb=0xF; pready only at T3, pslverr=0.
- Stalled read: paddr=0x3000_0010; arready arrives 3 cycles late, rvalid 2 cycles after that with rdata=0x1234_5678 -> arvalid and araddr stable for 4 cycles; pready for 1 cycle with prdata=0x1234_5678; prdata=0 on the next cycle.
- Skewed write channels: awready at T1, wready at T4 -> awvalid low from T2, wvalid held until T4, bready asserted from T5; exactly one AW and one W handshake.
- Error response: read with rresp=DECERR and rdata=0xBAD0_0000 -> pslverr=1, prdata=0xBAD0_0000. Write with bresp=SLVERR -> pslverr=1, prdata=0.
- Misaligned access with ALIGN_CHECK=1: paddr=0x3000_0002 -> no AW/W/AR valid ever asserted; pready=1, pslverr=1 at T1.
- Reset mid-read: assert rst_i while arvalid=1 and arready=0 -> all outputs 0 in the same cycle. After release, a write of 0x0000_00A5 to 0x0300_7000 completes with pslverr=0.

Source files
------------

// File: rtl/apb4_axil_bridge_pkg.sv
// Shared types and constants for the APB4-completer to AXI4-Lite-manager bridge.
package apb4_axil_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_RESP = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] PROT_DEFAULT = 3'b000;

   // EXOKAY counts as success: the bridge never issues exclusive accesses.
   function automatic logic resp_is_err(input logic [1:0] resp);
      case (resp)
         RESP_SLVERR, RESP_DECERR: return 1'b1;
         RESP_OKAY, RESP_EXOKAY:   return 1'b0;
      endcase
      return 1'b0;
   endfunction

endpackage

// File: rtl/apb4_axil_bridge.sv
// APB4 completer -> AXI4-Lite manager, one transfer in flight; best case pready 3 cycles after setup.
// Backpressure: pready is held off until the AXI response returns; a stalled target stalls APB.
module apb4_axil_bridge
   import apb4_axil_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter bit ALIGN_CHECK = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ADDR_WIDTH-1:0] s_apb_paddr,
   input  logic [2:0]            s_apb_pprot,
   input  logic                  s_apb_psel,
   input  logic                  s_apb_penable,
   input  logic                  s_apb_pwrite,
   input  logic [31:0]           s_apb_pwdata,
   input  logic [3:0]            s_apb_pstrb,
   output logic                  s_apb_pready,
   output logic [31:0]           s_apb_prdata,
   output logic                  s_apb_pslverr,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [2:0]            m_axi_awprot,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   output logic [31:0]           m_axi_wdata,
   output logic [3:0]            m_axi_wstrb,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   input  logic [1:0]            m_axi_bresp,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [2:0]            m_axi_arprot,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   input  logic [31:0]           m_axi_rdata,
   input  logic [1:0]            m_axi_rresp
);

   state_t                state_q, state_d;
   logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic                  arvalid_q, arvalid_d, rready_q, rready_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic [2:0]            awprot_q, awprot_d, arprot_q, arprot_d;
   logic [31:0]           wdata_q, wdata_d, prdata_q, prdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic                  pready_q, pready_d, pslverr_q, pslverr_d;
   logic                  setup, misaligned, aw_hs, w_hs;

   assign setup      = s_apb_psel && !s_apb_penable;
   assign misaligned = ALIGN_CHECK && (s_apb_paddr[1:0] != 2'b00);
   assign aw_hs      = awvalid_q && m_axi_awready;
   assign w_hs       = wvalid_q && m_axi_wready;

   always_comb begin
      state_d   = state_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      awaddr_d  = awaddr_q;
      awprot_d  = awprot_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      araddr_d  = araddr_q;
      arprot_d  = arprot_q;
      // APB response outputs are a one-cycle pulse, so they default back to 0.
      pready_d  = 1'b0;
      prdata_d  = '0;
      pslverr_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (setup) begin
               if (misaligned) begin
                  state_d   = ST_DONE;
                  pready_d  = 1'b1;
                  pslverr_d = 1'b1;
               end else if (s_apb_pwrite) begin
                  state_d   = ST_WR_REQ;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
                  awaddr_d  = s_apb_paddr;
                  awprot_d  = s_apb_pprot;
                  wdata_d   = s_apb_pwdata;
                  wstrb_d   = s_apb_pstrb;
               end else begin
                  state_d   = ST_RD_REQ;
                  arvalid_d = 1'b1;
                  araddr_d  = s_apb_paddr;
                  arprot_d  = s_apb_pprot;
               end
            end
         end
         ST_WR_REQ: begin
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               state_d  = ST_WR_RESP;
               bready_d = 1'b1;
            end
         end
         ST_WR_RESP: begin
            if (m_axi_bvalid && bready_q) begin
               bready_d  = 1'b0;
               state_d   = ST_DONE;
               pready_d  = 1'b1;
               pslverr_d = resp_is_err(m_axi_bresp);
            end
         end
         ST_RD_REQ: begin
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = ST_RD_RESP;
            end
         end
         ST_RD_RESP: begin
            if (m_axi_rvalid && rready_q) begin
               rready_d  = 1'b0;
               state_d   = ST_DONE;
               pready_d  = 1'b1;
               prdata_d  = m_axi_rdata;
               pslverr_d = resp_is_err(m_axi_rresp);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awaddr_q  <= '0;
         awprot_q  <= PROT_DEFAULT;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         araddr_q  <= '0;
         arprot_q  <= PROT_DEFAULT;
         pready_q  <= 1'b0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         awaddr_q  <= awaddr_d;
         awprot_q  <= awprot_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         araddr_q  <= araddr_d;
         arprot_q  <= arprot_d;
         pready_q  <= pready_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
      end
   end

   assign s_apb_pready  = pready_q;
   assign s_apb_prdata  = prdata_q;
   assign s_apb_pslverr = pslverr_q;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_awprot  = awprot_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_bready  = bready_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arprot  = arprot_q;
   assign m_axi_rready  = rready_q;

endmodule
